// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative radix-2 multiply/divide unit owning HI/LO
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, op, a, b     operation request (sampled in IDLE only) and operands
//   flush               abort the in-flight operation, blocks start in IDLE
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured in IDLE only
//   hi, lo              architectural HI/LO registers
//   busy                high while an operation is in RUN or FIX
//   done                one-cycle pulse after HI/LO take a result
module ex_muldiv_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      n_q, n_d;
    logic [1:0]         kind_q, kind_d;     // {full_width, divide}
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   m_q, m_d;           // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic [WIDTH-1:0] sext_half(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    // Operand preparation for the request presented at start.
    logic             op_signed, op_full, op_div;
    logic [WIDTH-1:0] eff_a, eff_b, mag_a, mag_b;
    logic             sgn_a, sgn_b;

    always_comb begin
        op_signed = ~op[0];
        op_full   = op[2];
        op_div    = op[1];
        if (op_full) begin
            eff_a = a;
            eff_b = b;
        end else if (op_signed) begin
            eff_a = sext_half(a[HALF-1:0]);
            eff_b = sext_half(b[HALF-1:0]);
        end else begin
            eff_a = {{HALF{1'b0}}, a[HALF-1:0]};
            eff_b = {{HALF{1'b0}}, b[HALF-1:0]};
        end
        sgn_a = op_signed & eff_a[WIDTH-1];
        sgn_b = op_signed & eff_b[WIDTH-1];
        mag_a = sgn_a ? -eff_a : eff_a;
        mag_b = sgn_b ? -eff_b : eff_b;
    end

    // One iteration of shift-add multiply and restoring divide.
    logic [WIDTH:0]     mul_sum, r_shift, diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        r_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = r_shift - {1'b0, m_q};
        // A negative difference (top bit set) means the divisor did not fit: restore.
        if (diff[WIDTH])
            div_next = {r_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign correction and result formatting for the FIX state.
    logic               res_neg;
    logic [2*WIDTH-1:0] prod_full;
    logic [WIDTH-1:0]   prod_half, quo, rem, fix_hi, fix_lo;

    always_comb begin
        res_neg   = sign_a_q ^ sign_b_q;
        prod_full = res_neg ? -acc_q : acc_q;
        // A half-width multiply ran only HALF shifts, so its product sits HALF bits up.
        prod_half = res_neg ? -acc_q[WIDTH+HALF-1:HALF] : acc_q[WIDTH+HALF-1:HALF];
        quo       = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (kind_q[0]) begin
            if (m_q == '0)
                fix_lo = '1;
            else if (kind_q[1])
                fix_lo = quo;
            else
                fix_lo = sext_half(quo[HALF-1:0]);
            // Division by zero leaves the dividend magnitude in the remainder,
            // so the normal remainder path already yields the effective dividend.
            fix_hi = kind_q[1] ? rem : sext_half(rem[HALF-1:0]);
        end else if (kind_q[1]) begin
            fix_hi = prod_full[2*WIDTH-1:WIDTH];
            fix_lo = prod_full[WIDTH-1:0];
        end else begin
            fix_hi = sext_half(prod_half[WIDTH-1:HALF]);
            fix_lo = sext_half(prod_half[HALF-1:0]);
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        kind_d   = kind_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        m_d      = m_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush) begin
                    state_d  = S_RUN;
                    n_d      = op_full ? CW'(WIDTH) : CW'(HALF);
                    kind_d   = {op_full, op_div};
                    sign_a_d = sgn_a;
                    sign_b_d = sgn_b;
                    if (op_div) begin
                        // Half-width dividends are pre-aligned to the top so the
                        // MSB-first loop needs only HALF iterations.
                        m_d   = mag_b;
                        acc_d = {{WIDTH{1'b0}}, op_full ? mag_a : (mag_a << HALF)};
                    end else begin
                        m_d   = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = kind_q[0] ? div_next : mul_next;
                    n_d   = n_q - CW'(1);
                    if (n_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    hi_d   = fix_hi;
                    lo_d   = fix_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            kind_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            m_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            kind_q   <= kind_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised iterative multiply/divide unit that sits beside the EX-stage ALU and owns the architectural HI/LO pair. It accepts one operation per start pulse and runs one radix-2 shift-add (multiply) or restoring-subtract (divide) iteration per cycle. It covers signed and unsigned, half-width (word) and full-width (doubleword) variants. While it works it holds `busy`, which the hazard unit uses to stall MFHI/MFLO and new mul/div issue.

## Interface
- `WIDTH`, 64: datapath width. Must be even and ≥ 8. `HALF` = WIDTH/2.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request to begin an operation. Sampled only in IDLE.
- `op`  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 DMULT, 101 DMULTU, 110 DDIV, 111 DDIVU.
- `a`, `b`  in  WIDTH  operands, already forwarded. Sampled with `start`.
- `flush`  in  1  abort the in-flight operation.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `busy`  out  1  high in RUN and FIX states.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO take a result.

## Operation
**States:** IDLE, RUN, FIX.
- **IDLE → RUN:** on `start & !flush`.
  - Latch magnitudes of the effective operands, the result-sign flags, and the op.
  - Load the iteration counter `n`: HALF for op[2]=0, WIDTH for op[2]=1.
- **RUN:** one iteration per edge, decrementing `n`. When `n` reaches 1, go to FIX on the next edge.
- **FIX:** apply sign correction, write HI/LO, return to IDLE, and assert `done` for one cycle.

**Effective operands:**
- Half-width ops use `a[HALF-1:0]` and `b[HALF-1:0]`, sign-extended (signed ops) or zero-extended (unsigned ops).
- Full-width ops use `a` and `b` unchanged.

**Multiply:**
- Unsigned shift-add over |a|·|b| into a 2·WIDTH accumulator.
- Negate the product in FIX if the operand signs differ.
- Full-width result: {hi,lo} = product.
- Half-width result: lo = sign-extended product[HALF-1:0], hi = sign-extended product[2·HALF-1:HALF]. This applies to both MULT and MULTU.

**Divide:**
- Restoring division of |a| by |b| with a (WIDTH+1)-bit partial remainder.
- Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
- lo = quotient, hi = remainder. Half-width results are sign-extended from bit HALF-1.
- Divide by zero (effective b = 0): lo = all ones, hi = effective dividend. Half-width results are sign-extended. The full iteration count still elapses.
- Signed overflow (MIN ÷ −1 at the op width): lo = MIN sign-extended, hi = 0.

**Other rules:**
- `flush` in RUN or FIX: next state IDLE. HI/LO are unchanged and there is no `done`. `flush` in IDLE blocks `start`.
- `start` while `busy` is ignored.
- `hi_we`/`lo_we` take effect only in IDLE. They are ignored in RUN and FIX.
- Simultaneous `start` and write in IDLE: the write updates HI/LO at that edge, and the later result overwrites them.

## Timing
- **Reset values:** state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0. Reset mid-operation discards all work.
- **Start edge:** let E0 be the edge that samples `start`. `busy`=1 from E0.
- **Iterations:** edges E1..En, with n = HALF or WIDTH.
- **Result edge, E(n+1):**
  - `hi`/`lo` update.
  - `busy`=0 and `done`=1 for the following cycle.
- **Latency:** HALF+1 cycles for word ops, WIDTH+1 for doubleword ops.
- **Back-to-back:** a new `start` is accepted at E(n+1)+1 at the earliest, i.e. while `done` is high.
- **MTHI/MTLO:** `hi`/`lo` are visible one cycle after the write edge.
- All outputs are registered.

## Test plan
- DMULTU a=0xFFFF_FFFF_FFFF_FFFF, b=2 → hi=0x1, lo=0xFFFF_FFFF_FFFF_FFFE; `done` 65 cycles after start; `busy` high for exactly 65 cycles.
- MULT a=−3, b=5 with garbage upper halves → lo=0xFFFF_FFFF_FFFF_FFF1, hi=0xFFFF_FFFF_FFFF_FFFF; `done` after 33 cycles.
- DDIV a=7, b=−2 → lo=0xFFFF_FFFF_FFFF_FFFD, hi=1. DDIV 0x8000_0000_0000_0000 ÷ −1 → lo=0x8000_0000_0000_0000, hi=0.
- DDIVU a=0x1234, b=0 → lo=0xFFFF_FFFF_FFFF_FFFF, hi=0x1234. DIVU 10/0 → lo=0xFFFF_FFFF_FFFF_FFFF, hi=0xA.
- Preload hi=0xAA via `hi_we`; start DMULT; `flush` at cycle 20 → `busy` low the next cycle, no `done`, hi=0xAA. A `start` during RUN is ignored and `lo_we` during RUN is ignored.
- Assert `reset` at cycle 30 of a DMULT → `hi`=`lo`=0, `busy`=0 immediately. The next start produces a correct result.
